// File: rtl/alu_muldiv_seq_if.sv
// Request/response handshake bundle for the multi-cycle MUL/DIVU/REMU sequencer.
interface alu_muldiv_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative MUL/DIVU/REMU sequencer that does all arithmetic on the core's shared ALU.
// Optional MULDIV_EARLY_EXIT_EN: stop multiplying once the remaining multiplier is zero.
module alu_muldiv_seq #(
  parameter logic [3:0] OP_ADD  = 4'd5,
  parameter logic [3:0] OP_SUB  = 4'd6,
  parameter logic [3:0] OP_SLTU = 4'd12
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_muldiv_seq_if.slave   bus,
  output logic              busy,
  output logic              alu_own,
  output logic [3:0]        alu_op,
  output logic [31:0]       alu_x,
  output logic [31:0]       alu_y,
  input  logic [31:0]       alu_result,
  input  logic              alu_less
);

  typedef enum logic [2:0] {
    IDLE, MUL_ADD, DIV_CMP, DIV_SUB, DONE
  } state_t;

  state_t      state, state_n;
  logic [4:0]  cnt;
  logic [1:0]  op_q;
  // r0: acc / rem, r1: mp / quo, r2: mc / d
  logic [31:0] r0, r1, r2;
  logic [31:0] ptl_q;
  logic        sub_q;
  logic [31:0] data_q;
  logic [31:0] ptl;
  logic        mul_fin;
  logic        last;
  logic [31:0] rem_n, quo_n;

  assign ptl   = {r0[30:0], r1[31]};
  assign last  = (cnt == 5'd31);
  assign rem_n = sub_q ? alu_result : ptl_q;
  assign quo_n = {r1[30:0], sub_q};

`ifdef MULDIV_EARLY_EXIT_EN
  assign mul_fin = (r1[31:1] == 31'd0);
`else
  assign mul_fin = last;
`endif

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_data  = data_q;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    alu_own = 1'b0;
    alu_op  = 4'd0;
    alu_x   = 32'd0;
    alu_y   = 32'd0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_op == 2'd0)
            state_n = MUL_ADD;
          else if (bus.req_op == 2'd3 || bus.req_b == 32'd0)
            state_n = DONE;
          else
            state_n = DIV_CMP;
        end
      end
      MUL_ADD: begin
        alu_own = 1'b1;
        alu_op  = OP_ADD;
        alu_x   = r0;
        alu_y   = r1[0] ? r2 : 32'd0;
        if (mul_fin) state_n = DONE;
      end
      DIV_CMP: begin
        alu_own = 1'b1;
        alu_op  = OP_SLTU;
        alu_x   = ptl;
        alu_y   = r2;
        state_n = DIV_SUB;
      end
      DIV_SUB: begin
        alu_own = 1'b1;
        alu_op  = OP_SUB;
        alu_x   = ptl_q;
        alu_y   = r2;
        state_n = last ? DONE : DIV_CMP;
      end
      DONE: begin
        if (bus.rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= 5'd0;
      op_q   <= 2'd0;
      r0     <= 32'd0;
      r1     <= 32'd0;
      r2     <= 32'd0;
      ptl_q  <= 32'd0;
      sub_q  <= 1'b0;
      data_q <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q <= bus.req_op;
            cnt  <= 5'd0;
            r0   <= 32'd0;
            if (bus.req_op == 2'd0) begin
              r1 <= bus.req_b;
              r2 <= bus.req_a;
            end else if (bus.req_op == 2'd3) begin
              data_q <= 32'd0;
            end else if (bus.req_b == 32'd0) begin
              data_q <= (bus.req_op == 2'd1) ? 32'hFFFF_FFFF : bus.req_a;
            end else begin
              r1 <= bus.req_a;
              r2 <= bus.req_b;
            end
          end
        end
        MUL_ADD: begin
          r0  <= alu_result;
          r1  <= r1 >> 1;
          r2  <= r2 << 1;
          cnt <= cnt + 5'd1;
          if (mul_fin) data_q <= alu_result;
        end
        DIV_CMP: begin
          // 33rd dividend bit forces a subtract when the partial exceeds 32 bits
          sub_q <= r0[31] | ~alu_less;
          ptl_q <= ptl;
        end
        DIV_SUB: begin
          r0  <= rem_n;
          r1  <= quo_n;
          cnt <= cnt + 5'd1;
          if (last) data_q <= (op_q == 2'd1) ? quo_n : rem_n;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed vectors, behavioural result/latency model.
// Honours MULDIV_EARLY_EXIT_EN for the expected MUL latencies.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy, alu_own, alu_less;
  logic [3:0]  alu_op;
  logic [31:0] alu_x, alu_y, alu_result;

  int tests = 0;
  int fails = 0;

  alu_muldiv_seq_if bus ();

  alu_muldiv_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .alu_own    (alu_own),
    .alu_op     (alu_op),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_result (alu_result),
    .alu_less   (alu_less)
  );

  always #5 clk = ~clk;

  // Shared ALU stand-in
  always_comb begin
    alu_result = 32'd0;
    if (alu_op == 4'd5)      alu_result = alu_x + alu_y;
    else if (alu_op == 4'd6) alu_result = alu_x - alu_y;
    alu_less = (alu_x < alu_y);
  end

`ifdef MULDIV_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [1:0] op,
      input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return a * b;
      2'd1:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op,
      input logic [31:0] b);
    int hi;
    if (op == 2'd0) begin
      if (!EE) return 33;
      hi = 0;
      for (int i = 0; i < 32; i++) if (b[i]) hi = i;
      return hi + 2;
    end
    if (op == 2'd3 || b == 0) return 1;
    return 65;
  endfunction

  // Compare process: every negedge while out of reset
  logic        active = 1'b0;
  logic        seen = 1'b0;
  logic        post_rst = 1'b0;
  int          k = 0;
  int          own = 0;
  int          exp_lat = 0;
  logic [31:0] exp_data = 32'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      active   = 1'b0;
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_alu_own", {31'd0, alu_own}, 32'd0);
        post_rst = 1'b0;
      end
      if (!alu_own)
        chk("alu_idle_zero", {alu_op, alu_x[27:0] | alu_y[27:0]}, 32'd0);
      else
        chk("alu_op_legal",
            {31'd0, alu_op == 4'd5 || alu_op == 4'd6 || alu_op == 4'd12},
            32'd1);
      chk("ready_vs_busy", {31'd0, bus.req_ready}, {31'd0, ~busy});
      if (active) begin
        k++;
        if (alu_own) own++;
        if (bus.rsp_valid) begin
          if (!seen) begin
            chk("latency", k, exp_lat);
            chk("alu_own_cycles", own, exp_lat - 1);
            seen = 1'b1;
          end
          chk("rsp_data", bus.rsp_data, exp_data);
          chk("ready_in_done", {31'd0, bus.req_ready}, 32'd0);
          if (bus.rsp_ready) active = 1'b0;
        end else if (k > 300) begin
          chk("rsp_timeout", 32'd0, 32'd1);
          active = 1'b0;
        end
      end else if (bus.rsp_valid) begin
        chk("spurious_rsp", 32'd1, 32'd0);
      end
      if (bus.req_valid && bus.req_ready) begin
        active   = 1'b1;
        seen     = 1'b0;
        k        = 0;
        own      = 0;
        exp_data = model_res(bus.req_op, bus.req_a, bus.req_b);
        exp_lat  = model_lat(bus.req_op, bus.req_b);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic finish_op(input logic [31:0] lit, input int lat,
                           input int hold);
    int n = 0;
    bit ok = 1'b0;
    logic [31:0] d0;
    for (int i = 0; i < 200; i++) begin
      n++;
      @(negedge clk);
      if (bus.rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("wait_rsp_timeout", 32'd0, 32'd1);
      return;
    end
    chk("lit_data", bus.rsp_data, lit);
    chk("lit_latency", n, lat);
    d0 = bus.rsp_data;
    for (int i = 0; i < hold; i++) @(negedge clk);
    if (hold > 0) begin
      chk("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("hold_data", bus.rsp_data, d0);
      chk("hold_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("rsp_dropped", {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] lit,
                     input int lat, input int hold);
    issue(op, a, b);
    finish_op(lit, lat, hold);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run(2'd0, 32'd7, 32'd6, 32'd42, EE ? 4 : 33, 0);
    run(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33, 0);
    run(2'd1, 32'd100, 32'd7, 32'd14, 65, 0);
    run(2'd2, 32'd100, 32'd7, 32'd2, 65, 0);
    run(2'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 65, 0);
    run(2'd2, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 65, 0);
    run(2'd1, 32'h1234_5678, 32'h0000_1234, 32'd65540, 65, 0);
    run(2'd2, 32'h1234_5678, 32'h0000_1234, 32'd3496, 65, 0);
    run(2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run(2'd2, 32'd5, 32'd0, 32'd5, 1, 0);
    run(2'd3, 32'd9, 32'd4, 32'd0, 1, 0);
    run(2'd0, 32'd12345, 32'd1000, 32'd12345000, EE ? 11 : 33, 10);
    run(2'd0, 32'd123, 32'd0, 32'd0, EE ? 2 : 33, 0);

    issue(2'd1, 32'd100, 32'd7);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (70) @(negedge clk);
    run(2'd0, 32'd3, 32'd3, 32'd9, EE ? 3 : 33, 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
